// File: rtl/inj_link_arbiter.sv
// Packet-granular round-robin arbiter sharing one credit-based NoC injection link
// among N_SRC sources; a grant is held from header flit to last payload flit.
module inj_link_arbiter #(
  parameter  int N_SRC     = 2,
  parameter  int FLIT_SIZE = 32,
  localparam int GW        = (N_SRC > 1) ? $clog2(N_SRC) : 1
) (
  input  logic                              clk_i,
  input  logic                              rst_ni,
  input  logic [N_SRC-1:0]                  src_rx_i,
  input  logic [N_SRC-1:0][FLIT_SIZE-1:0]   src_data_i,
  output logic [N_SRC-1:0]                  src_credit_o,
  output logic                              tx_o,
  output logic [FLIT_SIZE-1:0]              data_o,
  input  logic                              credit_i,
  output logic [GW-1:0]                     grant_o,
  output logic                              busy_o
);

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_HEADER  = 2'd1,
    S_SIZE    = 2'd2,
    S_PAYLOAD = 2'd3
  } state_e;

  state_e               state_q, state_d;
  logic [GW-1:0]        grant_q, grant_d;
  logic [GW-1:0]        last_grant_q, last_grant_d;
  logic [FLIT_SIZE-1:0] cnt_q, cnt_d;
  logic                 busy_q, busy_d;

  logic                 xfer_s;
  logic                 rr_found_s;
  logic [GW-1:0]        rr_pick_s;
  logic [GW-1:0]        rr_cand_s;
  int                   rr_sum_s;

  // Round-robin search starting one past the last completed grant.
  always_comb begin
    rr_found_s = 1'b0;
    rr_pick_s  = '0;
    rr_cand_s  = '0;
    rr_sum_s   = 0;
    for (int i = 1; i <= N_SRC; i++) begin
      rr_sum_s = int'(last_grant_q) + i;
      if (rr_sum_s >= N_SRC) begin
        rr_sum_s = rr_sum_s - N_SRC;
      end else begin
        rr_sum_s = rr_sum_s;
      end
      rr_cand_s = GW'(rr_sum_s);
      if (!rr_found_s && src_rx_i[rr_cand_s]) begin
        rr_found_s = 1'b1;
        rr_pick_s  = rr_cand_s;
      end else begin
        rr_found_s = rr_found_s;
      end
    end
  end

  // Link datapath follows the granted source; nothing is accepted in IDLE.
  always_comb begin
    tx_o         = 1'b0;
    data_o       = '0;
    src_credit_o = '0;
    if (state_q != S_IDLE) begin
      tx_o                  = src_rx_i[grant_q];
      data_o                = src_data_i[grant_q];
      src_credit_o[grant_q] = credit_i;
    end else begin
      tx_o         = 1'b0;
      data_o       = '0;
      src_credit_o = '0;
    end
  end

  assign xfer_s = (state_q != S_IDLE) && src_rx_i[grant_q] && credit_i;

  // Packet framing FSM: next-state, grant, size counter and round-robin pointer.
  always_comb begin
    state_d      = state_q;
    grant_d      = grant_q;
    last_grant_d = last_grant_q;
    cnt_d        = cnt_q;
    case (state_q)
      S_IDLE: begin
        if (rr_found_s) begin
          grant_d = rr_pick_s;
          state_d = S_HEADER;
        end else begin
          state_d = S_IDLE;
        end
      end
      S_HEADER: begin
        if (xfer_s) begin
          state_d = S_SIZE;
        end else begin
          state_d = S_HEADER;
        end
      end
      S_SIZE: begin
        if (xfer_s) begin
          cnt_d = data_o;
          if (data_o == '0) begin
            last_grant_d = grant_q;
            state_d      = S_IDLE;
          end else begin
            state_d = S_PAYLOAD;
          end
        end else begin
          state_d = S_SIZE;
        end
      end
      S_PAYLOAD: begin
        // cnt is at least 1 here, so the decrement can never wrap.
        if (xfer_s) begin
          cnt_d = cnt_q - FLIT_SIZE'(1);
          if (cnt_q == FLIT_SIZE'(1)) begin
            last_grant_d = grant_q;
            state_d      = S_IDLE;
          end else begin
            state_d = S_PAYLOAD;
          end
        end else begin
          state_d = S_PAYLOAD;
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
    busy_d = (state_d != S_IDLE);
  end

  // State registers; last_grant resets to N_SRC-1 so source 0 wins first.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q      <= S_IDLE;
      grant_q      <= '0;
      last_grant_q <= GW'(N_SRC - 1);
      cnt_q        <= '0;
      busy_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      grant_q      <= grant_d;
      last_grant_q <= last_grant_d;
      cnt_q        <= cnt_d;
      busy_q       <= busy_d;
    end
  end

  assign grant_o = grant_q;
  assign busy_o  = busy_q;

endmodule
